// File: rtl/result_drain_if.sv
// result_drain_if: tile-capture inputs, result-buffer write port and job handshake
// for the PE-array drain stage.
interface result_drain_if #(
    parameter int WIDTH  = 32,
    parameter int ROW1   = 2,
    parameter int COL2   = 5,
    parameter int ROW_PE = 4,
    parameter int COL_PE = 4
);
    localparam int NUM_TILES = ROW1 * COL2;
    localparam int ELEMS     = ROW_PE * COL_PE;
    localparam int TILE_BITS = ELEMS * WIDTH;
    localparam int ADDR_W    = $clog2(NUM_TILES * ELEMS);

    logic                          start;
    logic [NUM_TILES-1:0]          tile_valid;
    logic [NUM_TILES*TILE_BITS-1:0] tile_data;
    logic [NUM_TILES-1:0]          tile_ack;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [WIDTH-1:0]              wr_data;
    logic                          wr_ready;
    logic                          busy;
    logic                          done;

    modport master (
        output start, tile_valid, tile_data, wr_ready,
        input  tile_ack, wr_en, wr_addr, wr_data, busy, done
    );
    modport slave (
        input  start, tile_valid, tile_data, wr_ready,
        output tile_ack, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/result_drain.sv
// result_drain: captures each finished PE tile once and serialises it element by
// element into the result buffer, raising done when every tile of the job is written.
module result_drain #(
    parameter int WIDTH  = 32,
    parameter int ROW1   = 2,
    parameter int COL2   = 5,
    parameter int ROW_PE = 4,
    parameter int COL_PE = 4
) (
    input logic           clk,
    input logic           rst,
    result_drain_if.slave bus
);
    localparam int NUM_TILES = ROW1 * COL2;
    localparam int ELEMS     = ROW_PE * COL_PE;
    localparam int TILE_BITS = ELEMS * WIDTH;
    localparam int ADDR_W    = $clog2(NUM_TILES * ELEMS);
    localparam int TW        = NUM_TILES > 1 ? $clog2(NUM_TILES) : 1;
    localparam int EW        = ELEMS > 1 ? $clog2(ELEMS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t               state, state_n;
    logic [NUM_TILES-1:0] written, cand, ack, done_mask;
    logic [TW-1:0]        tile, pick;
    logic [EW-1:0]        elem;
    logic [TILE_BITS-1:0] buffer;
    logic                 found, last, job_start;

    // lowest-index candidate wins; the loop runs high to low so the last hit is the lowest
    always_comb begin
        cand  = bus.tile_valid & ~written;
        found = |cand;
        pick  = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--)
            if (cand[i]) pick = TW'(i);
    end

    assign last      = elem == EW'(ELEMS - 1);
    assign done_mask = written | (NUM_TILES'(1) << tile);
    assign job_start = (state == IDLE || state == DONE) && bus.start;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? SCAN : IDLE;
            SCAN:    state_n = found ? WRITE : SCAN;
            WRITE:   state_n = (bus.wr_ready && last) ? ((&done_mask) ? DONE : SCAN) : WRITE;
            DONE:    state_n = bus.start ? SCAN : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
            elem    <= '0;
            tile    <= '0;
            buffer  <= '0;
            ack     <= '0;
        end else begin
            ack <= '0;
            if (job_start) written <= '0;
            if (state == SCAN && found) begin
                tile   <= pick;
                elem   <= '0;
                buffer <= bus.tile_data[pick*TILE_BITS +: TILE_BITS];
                ack    <= NUM_TILES'(1) << pick;
            end
            if (state == WRITE && bus.wr_ready) begin
                elem <= last ? '0 : elem + EW'(1);
                if (last) written <= done_mask;
            end
        end
    end

    assign bus.tile_ack = ack;
    assign bus.wr_en    = state == WRITE;
    assign bus.wr_addr  = ADDR_W'(tile) * ADDR_W'(ELEMS) + ADDR_W'(elem);
    assign bus.wr_data  = buffer[elem*WIDTH +: WIDTH];
    assign bus.busy     = state == SCAN || state == WRITE;
    assign bus.done     = state == DONE;
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: randomized jobs against a scoreboard of expected tile order and
// per-element writes derived from the drain rules.
module tb_result_drain;
    localparam int WIDTH = 32, ROW1 = 2, COL2 = 5, ROW_PE = 4, COL_PE = 4;
    localparam int NT = ROW1 * COL2, EL = ROW_PE * COL_PE, TB = EL * WIDTH;
    localparam int AW = $clog2(NT * EL);

    typedef struct {logic [AW-1:0] a; logic [WIDTH-1:0] d;} wr_t;

    logic clk = 0, rst = 1;
    int checks = 0, errors = 0;
    int phase = 0, ready_mode = 0, nwrites = 0;
    logic [31:0] key = 0;
    logic [NT-1:0] mw = '0, v_prev = '0;
    logic stalled = 0;
    logic [AW-1:0] s_addr;
    logic [WIDTH-1:0] s_data;
    wr_t q[$];
    int ack_log[$];
    int ack_cnt[NT];

    result_drain_if #(.WIDTH(WIDTH), .ROW1(ROW1), .COL2(COL2), .ROW_PE(ROW_PE), .COL_PE(COL_PE)) bus();
    result_drain #(.WIDTH(WIDTH), .ROW1(ROW1), .COL2(COL2), .ROW_PE(ROW_PE), .COL_PE(COL_PE)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat(input int t, input int e, input logic [31:0] k);
        return {16'(t), 16'(e)} ^ k;
    endfunction

    function automatic int lowest(input logic [NT-1:0] m);
        for (int i = 0; i < NT; i++) if (m[i]) return i;
        return -1;
    endfunction

    // scoreboard: each ack names the lowest tile that was valid and not yet written
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stalled = 0;
            mw = '0;
        end else begin
            if (bus.tile_ack != '0) begin
                int et, at;
                logic [NT-1:0] eh;
                et = lowest(v_prev & ~mw);
                at = lowest(bus.tile_ack);
                eh = '0;
                if (et >= 0) eh[et] = 1'b1;
                check("ack_tile", bus.tile_ack, eh);
                if (at >= 0) begin
                    ack_log.push_back(at);
                    ack_cnt[at]++;
                end
                if (et >= 0) begin
                    mw[et] = 1'b1;
                    for (int e = 0; e < EL; e++) q.push_back('{AW'(et * EL + e), pat(et, e, key)});
                end
            end
            if (stalled) begin
                check("stall_en", bus.wr_en, 1);
                check("stall_addr", bus.wr_addr, s_addr);
                check("stall_data", bus.wr_data, s_data);
            end
            if (bus.wr_en && bus.wr_ready) begin
                nwrites++;
                if (q.size() == 0) check("wr_extra", 1, 0);
                else begin
                    wr_t w;
                    w = q.pop_front();
                    check("wr_addr", bus.wr_addr, w.a);
                    check("wr_data", bus.wr_data, w.d);
                end
            end
            stalled = bus.wr_en && !bus.wr_ready;
            s_addr = bus.wr_addr;
            s_data = bus.wr_data;
            if (bus.start && !bus.busy) mw = '0;
        end
        v_prev = bus.tile_valid;
    end

    task automatic step();
        logic [31:0] r;
        @(posedge clk);
        #1;
        phase++;
        bus.wr_ready = ready_mode == 0 ? 1'b1 :
                       ready_mode == 1 ? (phase % 4 == 0 || phase % 4 == 3) : 1'($urandom_range(0, 1));
        for (int t = 0; t < NT; t++)
            if (mw[t]) begin
                r = $urandom();
                bus.tile_data[t*TB +: TB] = {EL{r}};
            end
    endtask

    task automatic load(input logic [31:0] k);
        key = k;
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < EL; e++) bus.tile_data[t*TB + e*WIDTH +: WIDTH] = pat(t, e, k);
    endtask

    task automatic pulse_start();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!bus.done && n < bound) begin
            step();
            n++;
        end
        check("done_timeout", bus.done, 1);
    endtask

    task automatic wait_ack(input int t);
        int n = 0;
        while (!bus.tile_ack[t] && n < 500) begin
            step();
            n++;
        end
        check("ack_timeout", bus.tile_ack[t], 1);
    endtask

    task automatic check_job(input string tag, input int w0, input int a0);
        check({tag, "_writes"}, nwrites - w0, NT * EL);
        check({tag, "_acks"}, ack_log.size() - a0, NT);
        check({tag, "_queue"}, q.size(), 0);
    endtask

    initial begin
        int n, w0, a0, c0;
        int ooo[NT] = '{7, 2, 9, 0, 1, 3, 4, 5, 6, 8};
        bus.start = 0;
        bus.tile_valid = '0;
        bus.tile_data = '0;
        bus.wr_ready = 1;
        for (int t = 0; t < NT; t++) ack_cnt[t] = 0;
        repeat (3) step();
        rst = 0;
        step();
        check("rst_ack", bus.tile_ack, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_addr", bus.wr_addr, 0);
        check("rst_data", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);

        // job 1: all valid, no backpressure, plain {t,e} data
        load(0);
        bus.tile_valid = '1;
        w0 = nwrites; a0 = ack_log.size();
        pulse_start();
        check("j1_busy", bus.busy, 1);
        wait_done(400, n);
        check("j1_latency", n + 1, NT * (EL + 1) + 1);
        check_job("j1", w0, a0);
        for (int i = 0; i < NT; i++) check("j1_ack_order", ack_log[a0 + i], i);

        // job 2: tiles finish out of order
        step();
        load($urandom());
        bus.tile_valid = '0;
        bus.tile_valid[7] = 1;
        w0 = nwrites; a0 = ack_log.size();
        pulse_start();
        wait_ack(7);
        bus.tile_valid[2] = 1;
        wait_ack(2);
        bus.tile_valid[9] = 1;
        wait_ack(9);
        check("j2_not_done", bus.done, 0);
        bus.tile_valid = '1;
        wait_done(400, n);
        check_job("j2", w0, a0);
        for (int i = 0; i < NT; i++) check("j2_ack_order", ack_log[a0 + i], ooo[i]);

        // job 3: wr_ready 1,0,0,1 repeating
        step();
        load($urandom());
        ready_mode = 1;
        w0 = nwrites; a0 = ack_log.size();
        pulse_start();
        wait_done(2000, n);
        check_job("j3", w0, a0);

        // job 4: stale valid on tile 0, start pulsed while writing tile 3
        step();
        load($urandom());
        ready_mode = 2;
        w0 = nwrites; a0 = ack_log.size(); c0 = ack_cnt[0];
        pulse_start();
        wait_ack(3);
        pulse_start();
        check("j4_busy", bus.busy, 1);
        wait_done(2000, n);
        check_job("j4", w0, a0);
        check("j4_tile0_once", ack_cnt[0] - c0, 1);

        // job 5: back-to-back start from DONE
        load($urandom());
        w0 = nwrites; a0 = ack_log.size();
        pulse_start();
        check("j5_done_fall", bus.done, 0);
        wait_done(2000, n);
        check_job("j5", w0, a0);
        check("j5_first_tile", ack_log[a0], 0);

        // job 6: async reset mid-write of tile 4 element 8
        step();
        load($urandom());
        ready_mode = 0;
        pulse_start();
        n = 0;
        while (!(bus.wr_en && bus.wr_addr == AW'(4 * EL + 8)) && n < 400) begin
            step();
            n++;
        end
        check("j6_reach", bus.wr_addr, 4 * EL + 8);
        #2 rst = 1;
        #1;
        check("arst_ack", bus.tile_ack, 0);
        check("arst_wr_en", bus.wr_en, 0);
        check("arst_addr", bus.wr_addr, 0);
        check("arst_data", bus.wr_data, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        #2 rst = 0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.wr_en) n++;
        end
        check("post_rst_wr_en", n, 0);
        check("post_rst_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
